// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, oversampling FSM, and a FWFT FIFO (mode 0) or single holding register (mode 1).
// A word lands one clk after its final stop sample; valid/ready pops it, and a commit with no room drops it and pulses overrun.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLING   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  s_data_in,
  input  logic                  mode,
  input  logic [1:0]            parity_select,
  input  logic [1:0]            stop_select,
  output logic [DATA_WIDTH-1:0] p_data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int TW = $clog2(SAMPLING);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLING / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q;
  logic                    sync1_q, sync2_q;
  logic [TW-1:0]           tick_q;
  logic [BW-1:0]           bit_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [1:0]              psel_q;
  logic                    two_stop_q, stop_q, mode_q;
  logic                    perr_q, ferr_q, commit_q;
  logic                    par_en, par_odd, data_xor;

  assign par_en   = (psel_q == 2'b01) || (psel_q == 2'b10);
  assign par_odd  = (psel_q == 2'b10);
  assign data_xor = ^shift_q ^ sync2_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      psel_q     <= 2'b00;
      two_stop_q <= 1'b0;
      stop_q     <= 1'b0;
      mode_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      sync1_q  <= s_data_in;
      sync2_q  <= sync1_q;
      commit_q <= 1'b0;
      if (bclk) begin
        case (state_q)
          IDLE: begin
            if (!sync2_q) begin
              state_q    <= START;
              tick_q     <= '0;
              bit_q      <= '0;
              stop_q     <= 1'b0;
              perr_q     <= 1'b0;
              ferr_q     <= 1'b0;
              psel_q     <= parity_select;
              two_stop_q <= (stop_select == 2'b01);
              mode_q     <= mode;
            end
          end
          START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (tick_q == TICK_HALF) begin
              tick_q  <= '0;
              state_q <= sync2_q ? IDLE : DATA;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          DATA: begin
            if (tick_q == TICK_LAST) begin
              tick_q         <= '0;
              shift_q[bit_q] <= sync2_q;
              if (bit_q == BIT_LAST) begin
                state_q <= par_en ? PARITY : STOP;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          PARITY: begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              perr_q  <= par_odd ? ~data_xor : data_xor;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          STOP: begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (!sync2_q) ferr_q <= 1'b1;
              // Leave at the final mid-stop sample so a back-to-back start edge is caught.
              if (two_stop_q && !stop_q) begin
                stop_q <= 1'b1;
              end else begin
                state_q  <= IDLE;
                commit_q <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [EW-1:0] hold_q, word, head;
  logic          hold_vld_q, overrun_q, overrun_d;
  logic          full, empty, fifo_push, fifo_pop, hold_pop, hold_load;

  assign word      = {perr_q, ferr_q, shift_q};
  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign fifo_pop  = !mode && !empty && ready;
  assign fifo_push = commit_q && !mode_q && (!full || fifo_pop);
  assign hold_pop  = mode && hold_vld_q && ready;
  assign hold_load = commit_q && mode_q && (!hold_vld_q || hold_pop);
  assign overrun_d = commit_q && (mode_q ? (hold_vld_q && !hold_pop) : (full && !fifo_pop));

  always_comb begin
    cnt_d = cnt_q;
    case ({fifo_push, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_q] <= word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      if (fifo_push) wr_q <= wr_q + 1'b1;
      if (fifo_pop)  rd_q <= rd_q + 1'b1;
      if (hold_load) begin
        hold_q     <= word;
        hold_vld_q <= 1'b1;
      end else if (hold_pop) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

  assign valid   = mode ? hold_vld_q : !empty;
  assign head    = mode ? hold_q : mem_q[rd_q];
  assign overrun = overrun_q;
  assign {parity_err, frame_err, p_data_out} = valid ? head : '0;

endmodule
